mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Parametrised successor to the single-width data-memory wrapper.
- Sits between EX/MEM pipeline registers and a valid/ready data-memory port.
- Adds sized accesses (byte/half/word/dword) with byte enables, lane alignment, sign/zero extension and misalignment detection.
- Drives an explicit request/response handshake through an FSM, with a stall output back to the pipeline.

Parameters:
- DATA_W, 32, memory data width; 32 or 64 only.
- ADDR_W, 32, byte-address width.
- BE_W, DATA_W/8, byte-enable width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- mem_en  in  1  access requested this cycle; held with all request inputs until done.
- mem_wrt  in  1  1=store, 0=load.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data, right-justified.
- size  in  2  00=byte, 01=half, 10=word, 11=dword (legal only when DATA_W=64).
- sign_ext  in  1  load result sign-extended when 1, zero-extended when 0.
- mem_data  out  DATA_W  load result, right-justified and extended.
- done  out  1  one-cycle completion pulse.
- stall  out  1  hold upstream pipeline.
- misalign  out  1  qualifies done: access faulted, no memory request issued.
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts request.
- req_wr  out  1  request is a write.
- req_addr  out  ADDR_W  address aligned down to BE_W bytes.
- req_be  out  BE_W  byte enables.
- req_wdata  out  DATA_W  store data shifted into byte lanes.
- rsp_valid  in  1  read data valid (reads only; writes are posted).
- rsp_data  in  DATA_W  read data.

Behaviour:
- Reset (rst_n low at posedge): state IDLE; done=0, stall=0, misalign=0, req_valid=0, mem_data=0, timeout_err=0.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE, mem_en=0: stall=0; stay in IDLE.
- IDLE, mem_en=1: stall=1 combinationally; latch addr, size, sign_ext, mem_wrt and lane-shifted wdata.
  - Misaligned (half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0) or illegal size: go to DONE with misalign=1; no request issued.
  - Otherwise go to REQ.
- REQ: req_valid=1; request fields stable until req_ready.
  - On req_ready: store goes to DONE; load goes to RSP.
- RSP: req_valid=0; wait for rsp_valid, then capture rsp_data, shift down by lane offset, extend per size/sign_ext into mem_data; go to DONE.
- rsp_valid outside RSP is ignored.
- DONE: done=1 for exactly one cycle; stall=0; return to IDLE.
  - mem_data holds its value until the next load completes; stores leave it unchanged.
- Stall rule: stall = (state!=IDLE && state!=DONE) || (state==IDLE && mem_en).
- Minimum latency is 3 cycles from mem_en to done for loads and 2 for stores, with zero-wait memory.
- req_be: byte=1 bit, half=2 bits, word=4 bits, dword=all bits; each set shifted left by lane offset addr[log2(BE_W)-1:0].
- Back-to-back accesses: a new mem_en is sampled only in IDLE, so the cycle after DONE.
- Reset mid-operation: abort immediately to IDLE and drop req_valid; a late response is discarded because RSP is no longer active.

Optional Feature:
- Macro MEM_STAGE_TIMEOUT_EN.
- When defined:
  - Extra parameter TIMEOUT_CYC, default 255.
  - Extra output timeout_err (1 bit).
  - An 8+ bit counter clears on entry to REQ or RSP and increments each cycle spent there.
  - When the counter reaches TIMEOUT_CYC: go to DONE, pulse done with timeout_err=1, force mem_data=0 for loads.
  - timeout_err returns to 0 with done.
- When undefined: no counter and no port; REQ and RSP wait indefinitely.

Decomposition:
- Package mem_stage_pkg holds:
  - size_t enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - state_t enum (IDLE, REQ, RSP, DONE).
  - Function size_to_be(size) returning the unshifted byte-enable mask.
- One combinational sub-module, mem_lane_align: load-data shift-down plus sign/zero extension. It is instantiated once, keeping the FSM file focused on control.

Test Plan:
- Word load at addr 0x104, rsp_data=0xDEADBEEF, zero-wait memory -> req_be=4'hF, req_addr=0x104, done 3 cycles after mem_en, mem_data=0xDEADBEEF.
- Signed byte load at addr 0x103, rsp_data=0x80112233 -> req_be=4'b1000, mem_data=0xFFFFFF80; same access with sign_ext=0 -> mem_data=0x00000080.
- Half store at 0x202, wdata=0x0000ABCD, req_ready delayed 4 cycles -> req_valid held 5 cycles, req_be=4'b1100, req_wdata=0xABCD0000, stall high throughout, done 1 cycle after acceptance.
- Word load at 0x101 -> no req_valid, done=1 with misalign=1 one cycle after mem_en.
- rst_n low while in RSP, then rsp_valid arrives -> state IDLE, done never pulses, mem_data=0.
- With MEM_STAGE_TIMEOUT_EN and TIMEOUT_CYC=8: load with rsp_valid never asserted -> done and timeout_err=1 exactly 8 cycles after entering RSP, mem_data=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access size, FSM state and the
// unshifted byte-enable mask for each access size.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int MAX_BE_W = 8;

    function automatic logic [MAX_BE_W-1:0] size_to_be(input size_t sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load-data alignment: shifts the addressed lane down to bit 0, then
// sign- or zero-extends it according to the access size.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rawData,
    input  logic [OFF_W-1:0]  laneOff,
    input  size_t             accSize,
    input  logic              signExt,
    output logic [DATA_W-1:0] extData
);

    // Left-justify the lane, then shift back right: arithmetic for sign
    // extension, logical for zero extension.
    function automatic logic [DATA_W-1:0] extendLane(input logic [DATA_W-1:0] v,
                                                     input size_t sz,
                                                     input logic sx);
        int sh;
        logic signed [DATA_W-1:0] topJust;
        case (sz)
            SZ_B:    sh = DATA_W - 8;
            SZ_H:    sh = DATA_W - 16;
            SZ_W:    sh = DATA_W - 32;
            default: sh = 0;
        endcase
        topJust = signed'(v << sh);
        return sx ? $unsigned(topJust >>> sh) : $unsigned(topJust) >> sh;
    endfunction

    assign extData = extendLane(rawData >> {laneOff, 3'b000}, accSize, signExt);

endmodule

// File: rtl/mem_stage.sv
// Memory stage: sized, lane-aligned loads/stores over a valid/ready memory port.
// Optional request/response watchdog enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_en,
    input  logic                mem_wrt,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    output logic [DATA_W-1:0]   mem_data,
    output logic                done,
    output logic                stall,
    output logic                misalign,
    output logic                req_valid,
    input  logic                req_ready,
    output logic                req_wr,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [DATA_W/8-1:0] req_be,
    output logic [DATA_W-1:0]   req_wdata,
    input  logic                rsp_valid,
    input  logic [DATA_W-1:0]   rsp_data
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    state_t              state;
    logic [ADDR_W-1:0]   addrQ;
    size_t               sizeQ;
    logic                signExtQ;
    logic                wrtQ;
    logic [DATA_W-1:0]   wdataQ;
    logic [BE_W-1:0]     beQ;
    logic [BE_W-1:0]     beNext;
    logic [OFF_W-1:0]    laneOff;
    logic [DATA_W-1:0]   loadData;
    logic                badAccess;

    assign laneOff = addr[OFF_W-1:0];
    assign beNext  = BE_W'(size_to_be(size_t'(size))) << laneOff;

    // A dword is only legal on a 64-bit port.
    always_comb begin
        case (size_t'(size))
            SZ_B:    badAccess = 1'b0;
            SZ_H:    badAccess = addr[0];
            SZ_W:    badAccess = |addr[1:0];
            default: badAccess = (DATA_W != 64) || (|addr[2:0]);
        endcase
    end

    // Request fields are captured once at acceptance and held until done.
    always_ff @(posedge clk) begin
        if (state == IDLE && mem_en) begin
            addrQ    <= addr;
            sizeQ    <= size_t'(size);
            signExtQ <= sign_ext;
            wrtQ     <= mem_wrt;
            wdataQ   <= wdata << {laneOff, 3'b000};
            beQ      <= beNext;
        end
    end

    mem_lane_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) uAlign (
        .rawData (rsp_data),
        .laneOff (addrQ[OFF_W-1:0]),
        .accSize (sizeQ),
        .signExt (signExtQ),
        .extData (loadData)
    );

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC < 256) ? 8 : $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] waitCnt;
    logic             waitExpired;
    assign waitExpired = (waitCnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            misalign <= 1'b0;
            mem_data <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        if (badAccess) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                        end else begin
                            state <= REQ;
`ifdef MEM_STAGE_TIMEOUT_EN
                            waitCnt <= '0;
`endif
                        end
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        state <= wrtQ ? DONE : RSP;
                        done  <= wrtQ;
`ifdef MEM_STAGE_TIMEOUT_EN
                        waitCnt <= '0;
                    end else if (waitExpired) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        if (!wrtQ) mem_data <= '0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
`endif
                    end
                end
                RSP: begin
                    if (rsp_valid) begin
                        mem_data <= loadData;
                        state    <= DONE;
                        done     <= 1'b1;
`ifdef MEM_STAGE_TIMEOUT_EN
                    end else if (waitExpired) begin
                        mem_data    <= '0;
                        state       <= DONE;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
`endif
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    assign req_valid = (state == REQ);
    assign req_wr    = wrtQ;
    assign req_addr  = {addrQ[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign req_be    = beQ;
    assign req_wdata = wdataQ;
    assign stall     = (state == REQ) || (state == RSP) || (state == IDLE && mem_en);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized accesses
// compared against a byte-level reference model.
module tb_mem_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_en;
    logic              mem_wrt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        size;
    logic              sign_ext;
    logic [DATA_W-1:0] mem_data;
    logic              done;
    logic              stall;
    logic              misalign;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
`ifdef MEM_STAGE_TIMEOUT_EN
    logic              timeout_err;
`endif

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [31:0] refMem;

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
`ifdef MEM_STAGE_TIMEOUT_EN
        , .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_en    (mem_en),
        .mem_wrt   (mem_wrt),
        .addr      (addr),
        .wdata     (wdata),
        .size      (size),
        .sign_ext  (sign_ext),
        .mem_data  (mem_data),
        .done      (done),
        .stall     (stall),
        .misalign  (misalign),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
`ifdef MEM_STAGE_TIMEOUT_EN
        , .timeout_err (timeout_err)
`endif
    );

    task automatic check(input string tag, input string what,
                         input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    function automatic int nBytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit isMisaligned(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        return (a % nBytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] refBe(input logic [31:0] a, input logic [1:0] sz);
        int m;
        m = ((1 << nBytes(sz)) - 1) << int'(a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] refWdata(input logic [31:0] a, input logic [31:0] wd);
        logic [63:0] t;
        t = {32'b0, wd} << (8 * int'(a % 4));
        return t[31:0];
    endfunction

    // Gather the addressed bytes little-endian, then extend arithmetically.
    function automatic logic [31:0] refLoad(input logic [31:0] rd, input logic [31:0] a,
                                            input logic [1:0] sz, input bit sx);
        int off;
        int n;
        longint v;
        off = int'(a % 4);
        n   = nBytes(sz);
        v   = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(rd[8*(off+i) +: 8]) << (8 * i));
        if (sx && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // One access, acting as both the pipeline and the memory; the cycle in
    // which mem_en first rises is cycle 0.
    task automatic runAccess(input string tag, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [1:0] sz, input bit sx,
                             input int rdyDly, input int rspDly, input logic [31:0] rd);
        int cyc, doneCyc, acceptCyc, validCyc, fieldErr, stallErr, expDone, expValid;
        bit mis, expMis;
        cyc = 0; doneCyc = -1; acceptCyc = -1; validCyc = 0;
        fieldErr = 0; stallErr = 0; mis = 1'b0;
        expMis = isMisaligned(a, sz);
        @(negedge clk);
        mem_en = 1'b1; mem_wrt = wr; addr = a; wdata = wd; size = sz; sign_ext = sx;
        while (doneCyc < 0 && cyc < 60) begin
            if (cyc > 0) @(negedge clk);
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            #1;
            if (done) begin
                doneCyc = cyc;
                mis     = misalign;
                mem_en  = 1'b0;
                if (stall !== 1'b0) stallErr++;
            end else begin
                if (stall !== 1'b1) stallErr++;
                if (req_valid) begin
                    if (req_wr !== wr || req_addr !== (a & ~32'd3) ||
                        req_be !== refBe(a, sz) || req_wdata !== refWdata(a, wd)) fieldErr++;
                    if (validCyc >= rdyDly) begin
                        req_ready = 1'b1;
                        acceptCyc = cyc;
                    end
                    validCyc++;
                    rsp_valid = 1'($urandom_range(0, 1));
                    rsp_data  = $urandom;
                end else if (acceptCyc >= 0) begin
                    rsp_valid = (cyc > acceptCyc + rspDly);
                    rsp_data  = rsp_valid ? rd : $urandom;
                end else begin
                    rsp_valid = 1'($urandom_range(0, 1));
                    rsp_data  = $urandom;
                end
            end
            cyc++;
        end
        if (expMis) begin
            expDone = 1; expValid = 0;
        end else if (wr) begin
            expDone = 2 + rdyDly; expValid = rdyDly + 1;
        end else begin
            expDone = 3 + rdyDly + rspDly; expValid = rdyDly + 1;
            refMem  = refLoad(rd, a, sz, sx);
        end
        check(tag, "done_cycle", 64'(doneCyc), 64'(expDone));
        check(tag, "valid_cycles", 64'(validCyc), 64'(expValid));
        check(tag, "misalign", 64'(mis), 64'(expMis));
        check(tag, "req_fields", 64'(fieldErr), 64'd0);
        check(tag, "stall", 64'(stallErr), 64'd0);
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        #1;
        check(tag, "done_pulse", 64'(done), 64'd0);
        check(tag, "stall_idle", 64'(stall), 64'd0);
        check(tag, "mem_data", 64'(mem_data), 64'(refMem));
    endtask

    initial begin
        int doneSeen;
`ifdef MEM_STAGE_TIMEOUT_EN
        int  toCyc;
        int  toDone;
        bit  toErr;
`endif
        rst_n = 1'b0; mem_en = 1'b0; mem_wrt = 1'b0; addr = '0; wdata = '0;
        size = 2'd0; sign_ext = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        refMem = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset", "done", 64'(done), 64'd0);
        check("reset", "stall", 64'(stall), 64'd0);
        check("reset", "misalign", 64'(misalign), 64'd0);
        check("reset", "req_valid", 64'(req_valid), 64'd0);
        check("reset", "mem_data", 64'(mem_data), 64'd0);
        rst_n = 1'b1;

        runAccess("word_ld", 1'b0, 32'h104, $urandom, 2'd2, 1'b0, 0, 0, 32'hDEADBEEF);
        check("word_ld", "value", 64'(mem_data), 64'hDEADBEEF);
        runAccess("byte_sx", 1'b0, 32'h103, $urandom, 2'd0, 1'b1, 0, 0, 32'h80112233);
        check("byte_sx", "value", 64'(mem_data), 64'hFFFFFF80);
        runAccess("byte_zx", 1'b0, 32'h103, $urandom, 2'd0, 1'b0, 0, 0, 32'h80112233);
        check("byte_zx", "value", 64'(mem_data), 64'h00000080);
        runAccess("half_st", 1'b1, 32'h202, 32'h0000ABCD, 2'd1, 1'b0, 4, 0, 32'h0);
        runAccess("word_mis", 1'b0, 32'h101, $urandom, 2'd2, 1'b0, 0, 0, 32'h0);
        runAccess("word_ld2", 1'b0, 32'h100, $urandom, 2'd2, 1'b0, 1, 2, 32'hCAFEF00D);

        // Reset while waiting in RSP; the late response must be dropped.
        @(negedge clk);
        mem_en = 1'b1; mem_wrt = 1'b0; addr = 32'h100; size = 2'd2; sign_ext = 1'b0;
        @(negedge clk);
        #1;
        check("rst_rsp", "req_valid_req", 64'(req_valid), 64'd1);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        check("rst_rsp", "req_valid_rsp", 64'(req_valid), 64'd0);
        check("rst_rsp", "stall_rsp", 64'(stall), 64'd1);
        rst_n = 1'b0; mem_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h12345678;
        #1;
        doneSeen = int'(done);
        check("rst_rsp", "stall", 64'(stall), 64'd0);
        check("rst_rsp", "req_valid", 64'(req_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rsp_valid = 1'b0;
            #1;
            doneSeen += int'(done);
        end
        check("rst_rsp", "done_seen", 64'(doneSeen), 64'd0);
        check("rst_rsp", "mem_data", 64'(mem_data), 64'd0);
        refMem = '0;

`ifdef MEM_STAGE_TIMEOUT_EN
        // Load that never gets a response: RSP entered at cycle 2, done at 10.
        @(negedge clk);
        mem_en = 1'b1; mem_wrt = 1'b0; addr = 32'h100; size = 2'd2; sign_ext = 1'b0;
        req_ready = 1'b1; rsp_valid = 1'b0;
        toCyc = 0; toDone = -1; toErr = 1'b0;
        while (toDone < 0 && toCyc < 40) begin
            @(negedge clk);
            toCyc++;
            #1;
            if (done) begin
                toDone = toCyc; toErr = timeout_err; mem_en = 1'b0; req_ready = 1'b0;
            end
        end
        check("timeout", "done_cycle", 64'(toDone), 64'd10);
        check("timeout", "timeout_err", 64'(toErr), 64'd1);
        check("timeout", "mem_data", 64'(mem_data), 64'd0);
        @(negedge clk);
        #1;
        check("timeout", "err_clear", 64'(timeout_err), 64'd0);
`endif

        for (int k = 0; k < 40; k++) begin
            logic [1:0]  rsz;
            logic [31:0] ra;
            rsz = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 3) != 0) ra = ra & ~(32'(nBytes(rsz)) - 32'd1);
            runAccess("rnd", 1'($urandom_range(0, 1)), ra, $urandom, rsz,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
